edp_fm_arbiter: RTL

//  Sequences and arbitrates the EDP fast-memory (AC block) RAM between two

---
 rtl/edp_fm_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/edp_fm_arbiter.sv
// EDP fast-memory sequencer/arbiter: EBOX (read/write) vs diagnostic EBUS (read), shared FM strobes, parity.
// Latency: request presented in IDLE -> one-cycle ack 3 cycles later (read and write); one access in flight.
// Backpressure: requesters hold req until their ack; requests are sampled only in IDLE, others wait.
// Optional build macro FM_PARITY_CHECK_EN enables odd write parity generation and sticky read-parity error.
module edp_fm_arbiter #(
    parameter int DATA_W       = 36,
    parameter int ADR_W        = 4,
    parameter int BLK_W        = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_edp_h,
    input  logic              mr_reset_h,
    input  logic              ebox_req_h,
    input  logic              ebox_write_h,
    input  logic [BLK_W-1:0]  ebox_block_h,
    input  logic [ADR_W-1:0]  ebox_adr_h,
    input  logic [DATA_W-1:0] ebox_wdata_h,
    output logic              ebox_ack_h,
    output logic [DATA_W-1:0] ebox_rdata_h,
    input  logic              diag_req_h,
    input  logic [BLK_W-1:0]  diag_block_h,
    input  logic [ADR_W-1:0]  diag_adr_h,
    output logic              diag_ack_h,
    output logic [DATA_W-1:0] diag_rdata_h,
    output logic [BLK_W-1:0]  fm_block_h,
    output logic [ADR_W-1:0]  fm_adr_h,
    output logic              fm_write_l,
    output logic [DATA_W-1:0] fm_wdata_h,
    output logic              fm_wpar_h,
    input  logic [DATA_W-1:0] fm_rdata_h,
    input  logic              fm_rpar_h,
    input  logic              err_clr_h,
    output logic              fm_parity_err_h
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ADR    = 3'd1,
        RD_DATA   = 3'd2,
        WR_SETUP  = 3'd3,
        WR_STROBE = 3'd4,
        ACK       = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             owner_diag;   // 1 = current access belongs to the diag port
    logic [CNT_W-1:0] starve_cnt;
    logic             diag_wins;
    logic             grant_ebox;
    logic             grant_diag;

    // Diag only beats a pending EBOX request once it has been passed over STARVE_LIMIT times.
    assign diag_wins  = diag_req_h && (!ebox_req_h || (starve_cnt == LIMIT));
    assign grant_ebox = (state == IDLE) && ebox_req_h && !diag_wins;
    assign grant_diag = (state == IDLE) && diag_wins;

    // Next-state decode for the access sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_ebox) begin
                    state_nxt = ebox_write_h ? WR_SETUP : RD_ADR;
                end else if (grant_diag) begin
                    state_nxt = RD_ADR;
                end
            end
            RD_ADR:    state_nxt = RD_DATA;
            RD_DATA:   state_nxt = ACK;
            WR_SETUP:  state_nxt = WR_STROBE;
            WR_STROBE: state_nxt = ACK;
            ACK:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // State register, owner, registered FM address/strobe and completion pulses.
    always_ff @(posedge clk_edp_h) begin
        if (mr_reset_h) begin
            state      <= IDLE;
            owner_diag <= 1'b0;
            fm_block_h <= '0;
            fm_adr_h   <= '0;
            fm_wdata_h <= '0;
            fm_write_l <= 1'b1;
            ebox_ack_h <= 1'b0;
            diag_ack_h <= 1'b0;
        end else begin
            state      <= state_nxt;
            // Strobe is low only for the single WR_STROBE cycle; WR_STROBE is reachable from EBOX only.
            fm_write_l <= (state_nxt != WR_STROBE);
            ebox_ack_h <= (state_nxt == ACK) && !owner_diag;
            diag_ack_h <= (state_nxt == ACK) && owner_diag;
            if (grant_ebox) begin
                owner_diag <= 1'b0;
                fm_block_h <= ebox_block_h;
                fm_adr_h   <= ebox_adr_h;
                if (ebox_write_h) begin
                    fm_wdata_h <= ebox_wdata_h;
                end
            end else if (grant_diag) begin
                owner_diag <= 1'b1;
                fm_block_h <= diag_block_h;
                fm_adr_h   <= diag_adr_h;
            end
        end
    end

    // Ack timing above keys off state_nxt so the ack edge coincides with the ACK state.
    // Owner's ack is registered from owner_diag, which is stable from grant until IDLE.

    // Starvation counter: counts EBOX wins against a waiting diag request, saturating at the limit.
    always_ff @(posedge clk_edp_h) begin
        if (mr_reset_h) begin
            starve_cnt <= '0;
        end else if (!diag_req_h || grant_diag) begin
            starve_cnt <= '0;
        end else if (grant_ebox && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Read data capture into the owning requester's holding register.
    always_ff @(posedge clk_edp_h) begin
        if (mr_reset_h) begin
            ebox_rdata_h <= '0;
            diag_rdata_h <= '0;
        end else if (state == RD_DATA) begin
            if (owner_diag) begin
                diag_rdata_h <= fm_rdata_h;
            end else begin
                ebox_rdata_h <= fm_rdata_h;
            end
        end
    end

`ifdef FM_PARITY_CHECK_EN
    logic rd_par_bad;

    // Stored word plus parity bit must hold an odd number of ones.
    assign rd_par_bad = (state == RD_DATA) && ((^{fm_rdata_h, fm_rpar_h}) == 1'b0);

    // Write parity travels with the write data; read parity error is sticky, set wins over clear.
    always_ff @(posedge clk_edp_h) begin
        if (mr_reset_h) begin
            fm_wpar_h       <= 1'b0;
            fm_parity_err_h <= 1'b0;
        end else begin
            if (grant_ebox && ebox_write_h) begin
                fm_wpar_h <= ~^ebox_wdata_h;
            end
            if (rd_par_bad) begin
                fm_parity_err_h <= 1'b1;
            end else if (err_clr_h) begin
                fm_parity_err_h <= 1'b0;
            end
        end
    end
`else
    logic unused_par;

    assign unused_par      = ^{err_clr_h, fm_rpar_h};
    assign fm_wpar_h       = 1'b0;
    assign fm_parity_err_h = 1'b0;
`endif

endmodule
